instr_encoder_loader: RTL and testbench
=======================================

// Module: instr_encoder_loader
// PURPOSE
//  Inverse of the decode path. Accepts symbolic instruction requests (op, rd, rs1, rs2, imm)
//  and encodes each into a 32-bit RV32I word with the opcode/fn3/fn7 our decoders expect.
//  Buffers encoded words in a FIFO and writes them to instruction memory at consecutive
//  word addresses. Used by the test harness to load programs before the pipeline runs.
// PARAMETERS
//  DEPTH       4          FIFO entries (power of 2, >=2)
//  ADDR_WIDTH  32         memory address width
//  BASE_ADDR   32'h0      first write address after start
// PORTS
//  clk        in   1           clock; all state updates on rising edge
//  rst        in   1           synchronous, active-high reset
//  start      in   1           pulse: clear FIFO/err/count, addr<=BASE_ADDR, enter LOAD
//  in_valid   in   1           request valid
//  in_ready   out  1           request accepted when in_valid&in_ready
//  in_op      in   4           0 ADD,1 SUB,2 SLT,3 XOR,4 OR,5 AND,6 ADDI,7 SLLI,8 SRLI,
//                              9 ANDI,10 LW,11 SW,12 BNE,13 JAL,14 LUI, 15 illegal
//  in_rd/in_rs1/in_rs2 in 5    register fields (ignored where format has none)
//  in_imm     in   32          immediate, byte offset for BNE/JAL, upper value for LUI
//  in_last    in   1           marks final request of program
//  mem_we     out  1           write strobe; word transfers when mem_we&mem_ready
//  mem_addr   out  ADDR_WIDTH  byte address of word
//  mem_wdata  out  32          encoded instruction
//  mem_ready  in   1           memory accepts write
//  busy/done  out  1           state == LOAD / state == DONE
//  err        out  1           sticky: illegal op (15) seen since start
//  count      out  16          words written since start
// BEHAVIOUR
//  Reset: state IDLE; FIFO empty; in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0,
//   busy=0, done=0, err=0, count=0. Reset overrides start and any in-flight transfer.
//  FSM: IDLE -start-> LOAD; LOAD -(last word written)-> DONE; DONE -start-> LOAD.
//   start in LOAD restarts: FIFO flushed, pending last discarded, counters cleared.
//  in_ready = (state==LOAD) & !full & !last_seen. No push when full even if popping.
//  Encoding is combinational on accept; word pushed same edge. FIFO head drives
//   mem_we/mem_wdata; earliest mem_we is cycle after accept (latency 1). One word/cycle max.
//  On mem_we&mem_ready: pop, mem_addr+=4 (wraps mod 2^ADDR_WIDTH), count+=1 (saturates).
//  mem_we held with stable addr/data while mem_ready=0.
//  Formats: R op 0110011 fn7 0000000 (SUB 0100000), fn3 ADD/SUB 000,SLT 010,XOR 100,OR 110,
//   AND 111. I-ALU op 0010011: ADDI 000, ANDI 111 imm[11:0]; SLLI 001, SRLI 101 with
//   fn7=0, shamt=imm[4:0]. LW op 0000011 fn3 010 I-imm. SW op 0100011 fn3 010 S-imm.
//   BNE op 1100011 fn3 001 B-imm imm[12:1]. JAL op 1101111 J-imm imm[20:1]. LUI op 0110111
//   imm[31:12]. Out-of-range bits silently truncated; BNE/JAL imm[0] dropped.
//  Illegal op: accepted (handshake completes), nothing pushed, err set; if in_last, last
//   still honoured.
//  last_seen set when last request accepted; LOAD->DONE on the edge that writes the word
//   carrying last (or, if that request was illegal, when FIFO drains empty).
//  DONE: in_ready=0, mem_we=0, done=1; mem_addr/count hold final values.
//  Requests while IDLE/DONE are not accepted (in_ready=0).
// TESTING
//  T1 start; push ADD rd=3 rs1=1 rs2=2, mem_ready=1 -> next cycle mem_we=1 addr 0
//     wdata 32'h002081B3; count=1.
//  T2 push SUB x5,x6,x7; ADDI x1,x0,-1; SW x2,8(x1) -> 32'h407302B3, 32'hFFF00093,
//     32'h0020A423 at addr 0,4,8.
//  T3 BNE x1,x2,-4 then JAL x1,+2048 in_last -> 32'hFE209EE3, 32'h001000EF; done=1 after
//     second write; in_ready=0.
//  T4 mem_ready=0, push DEPTH+1 reqs -> in_ready drops after DEPTH; mem_we/addr/data
//     stable; release -> all words in order, addr +4 each.
//  T5 in_op=15 between two ADDs -> err=1, only 2 words written at 0,4; start clears err.
//  T6 rst or start mid-load with 3 in FIFO -> mem_we=0 next cycle, FIFO empty, addr=BASE.

Source files
------------

// File: rtl/instr_encoder_loader.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder_loader
// Description : Encodes symbolic RV32I requests, buffers the words in a FIFO and
//               writes them to instruction memory at consecutive word addresses.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder_loader #(
  parameter int                    DEPTH      = 4,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_op,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  input  logic [31:0]           in_imm,
  input  logic                  in_last,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [15:0]           count
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [31:0]    fifo_data [DEPTH];
  logic [DEPTH-1:0] fifo_last;
  logic [PW:0]    wr_ptr, rd_ptr;
  logic           last_seen;

  logic           full, empty;
  logic           accept, push, pop;
  logic           head_last;
  logic [31:0]    enc;
  logic           legal;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign head_last = fifo_last[rd_ptr[PW-1:0]];

  assign in_ready  = (state_q == S_LOAD) && !full && !last_seen;
  assign accept    = in_valid && in_ready;
  assign push      = accept && legal;
  assign mem_we    = (state_q == S_LOAD) && !empty;
  assign pop       = mem_we && mem_ready;
  assign mem_wdata = mem_we ? fifo_data[rd_ptr[PW-1:0]] : 32'h0;
  assign busy      = (state_q == S_LOAD);
  assign done      = (state_q == S_DONE);

  always_comb begin
    enc   = 32'h0;
    legal = 1'b1;
    case (in_op)
      4'd0:  enc = {7'b0000000, in_rs2, in_rs1, 3'b000, in_rd, 7'b0110011};
      4'd1:  enc = {7'b0100000, in_rs2, in_rs1, 3'b000, in_rd, 7'b0110011};
      4'd2:  enc = {7'b0000000, in_rs2, in_rs1, 3'b010, in_rd, 7'b0110011};
      4'd3:  enc = {7'b0000000, in_rs2, in_rs1, 3'b100, in_rd, 7'b0110011};
      4'd4:  enc = {7'b0000000, in_rs2, in_rs1, 3'b110, in_rd, 7'b0110011};
      4'd5:  enc = {7'b0000000, in_rs2, in_rs1, 3'b111, in_rd, 7'b0110011};
      4'd6:  enc = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b0010011};
      4'd7:  enc = {7'b0000000, in_imm[4:0], in_rs1, 3'b001, in_rd, 7'b0010011};
      4'd8:  enc = {7'b0000000, in_imm[4:0], in_rs1, 3'b101, in_rd, 7'b0010011};
      4'd9:  enc = {in_imm[11:0], in_rs1, 3'b111, in_rd, 7'b0010011};
      4'd10: enc = {in_imm[11:0], in_rs1, 3'b010, in_rd, 7'b0000011};
      4'd11: enc = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'b0100011};
      4'd12: enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b001,
                    in_imm[4:1], in_imm[11], 7'b1100011};
      4'd13: enc = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                    in_rd, 7'b1101111};
      4'd14: enc = {in_imm[31:12], in_rd, 7'b0110111};
      default: legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr[PW-1:0]] <= enc;
      fifo_last[wr_ptr[PW-1:0]] <= in_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // An illegal final request never reaches the FIFO, so draining empty ends the load.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_LOAD;
      S_LOAD: begin
        if (start)
          state_d = S_LOAD;
        else if ((pop && head_last) || (last_seen && empty))
          state_d = S_DONE;
      end
      S_DONE: if (start) state_d = S_LOAD;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || start) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      last_seen <= 1'b0;
      err       <= 1'b0;
      count     <= 16'h0;
      mem_addr  <= BASE_ADDR;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        mem_addr <= mem_addr + ADDR_WIDTH'(4);
        if (count != 16'hFFFF)
          count <= count + 16'd1;
      end
      if (accept && in_last)
        last_seen <= 1'b1;
      if (accept && !legal)
        err <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_encoder_loader
// Description : Directed and randomized checks of instr_encoder_loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_encoder_loader;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, in_last, mem_ready;
  logic [3:0]  in_op;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;
  logic        in_ready, mem_we, busy, done, err;
  logic [31:0] mem_addr, mem_wdata;
  logic [15:0] count;

  int checks = 0;
  int failures = 0;
  bit rnd_ready = 1'b0;

  logic [31:0] exp_a[$], exp_d[$], got_a[$], got_d[$];
  logic [31:0] exp_addr;
  logic        exp_err;

  instr_encoder_loader #(.DEPTH(DEPTH), .ADDR_WIDTH(32), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .in_last(in_last), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .busy(busy), .done(done), .err(err), .count(count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we && mem_ready) begin
      got_a.push_back(mem_addr);
      got_d.push_back(mem_wdata);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Field placement from the RV32I format tables.
  function automatic logic [31:0] ref_enc(input logic [3:0] op, input logic [31:0] rd,
                                          input logic [31:0] rs1, input logic [31:0] rs2,
                                          input logic [31:0] imm);
    logic [31:0] f3_tab [6];
    f3_tab = '{0, 0, 2, 4, 6, 7};
    if (op <= 5)
      return ((op == 1 ? 32'd32 : 32'd0) << 25) | (rs2 << 20) | (rs1 << 15)
             | (f3_tab[op] << 12) | (rd << 7) | 32'h33;
    case (op)
      6:  return ((imm & 32'hFFF) << 20) | (rs1 << 15) | (rd << 7) | 32'h13;
      7:  return ((imm & 31) << 20) | (rs1 << 15) | (32'd1 << 12) | (rd << 7) | 32'h13;
      8:  return ((imm & 31) << 20) | (rs1 << 15) | (32'd5 << 12) | (rd << 7) | 32'h13;
      9:  return ((imm & 32'hFFF) << 20) | (rs1 << 15) | (32'd7 << 12) | (rd << 7) | 32'h13;
      10: return ((imm & 32'hFFF) << 20) | (rs1 << 15) | (32'd2 << 12) | (rd << 7) | 32'h03;
      11: return (((imm >> 5) & 127) << 25) | (rs2 << 20) | (rs1 << 15) | (32'd2 << 12)
                 | ((imm & 31) << 7) | 32'h23;
      12: return (((imm >> 12) & 1) << 31) | (((imm >> 5) & 63) << 25) | (rs2 << 20)
                 | (rs1 << 15) | (32'd1 << 12) | (((imm >> 1) & 15) << 8)
                 | (((imm >> 11) & 1) << 7) | 32'h63;
      13: return (((imm >> 20) & 1) << 31) | (((imm >> 1) & 1023) << 21)
                 | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 255) << 12) | (rd << 7) | 32'h6F;
      default: return (imm & 32'hFFFFF000) | (rd << 7) | 32'h37;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_ready) mem_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    exp_a.delete(); exp_d.delete(); got_a.delete(); got_d.delete();
    exp_addr = 32'h0;
    exp_err  = 1'b0;
  endtask

  task automatic push(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm, input logic last);
    int n = 0;
    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_last = last;
    in_valid = 1'b1;
    while (!in_ready && n < 300) begin
      step();
      n++;
    end
    if (n == 300) check("push_accept_timeout", {63'h0, in_ready}, 64'h1);
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (op != 4'd15) begin
      exp_a.push_back(exp_addr);
      exp_d.push_back(ref_enc(op, 32'(rd), 32'(rs1), 32'(rs2), imm));
      exp_addr += 4;
    end else begin
      exp_err = 1'b1;
    end
  endtask

  task automatic wait_done();
    int n = 0;
    rnd_ready = 1'b0;
    mem_ready = 1'b1;
    while (!done && n < 500) begin
      step();
      n++;
    end
    check("done_reached", {63'h0, done}, 64'h1);
    check("done_in_ready", {63'h0, in_ready}, 64'h0);
    check("done_mem_we", {63'h0, mem_we}, 64'h0);
  endtask

  task automatic compare_words(input string tag);
    check({tag, "_nwords"}, 64'(got_a.size()), 64'(exp_a.size()));
    for (int i = 0; i < got_a.size() && i < exp_a.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), 64'(got_a[i]), 64'(exp_a[i]));
      check($sformatf("%s_data%0d", tag, i), 64'(got_d[i]), 64'(exp_d[i]));
    end
  endtask

  initial begin
    logic [31:0] hold_a, hold_d;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; mem_ready = 1'b0;
    in_op = 4'd0; in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_imm = 32'h0;
    exp_addr = 32'h0; exp_err = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    check("rst_busy", {63'h0, busy}, 64'h0);
    check("rst_done", {63'h0, done}, 64'h0);
    check("rst_in_ready", {63'h0, in_ready}, 64'h0);
    check("rst_mem_we", {63'h0, mem_we}, 64'h0);
    check("rst_addr", 64'(mem_addr), 64'h0);
    check("rst_wdata", 64'(mem_wdata), 64'h0);
    check("rst_err", {63'h0, err}, 64'h0);
    check("rst_count", 64'(count), 64'h0);

    // T1
    do_start();
    check("t1_busy", {63'h0, busy}, 64'h1);
    check("t1_in_ready", {63'h0, in_ready}, 64'h1);
    mem_ready = 1'b1;
    push(4'd0, 5'd3, 5'd1, 5'd2, 32'h0, 1'b0);
    check("t1_mem_we", {63'h0, mem_we}, 64'h1);
    check("t1_addr", 64'(mem_addr), 64'h0);
    check("t1_wdata", 64'(mem_wdata), 64'h002081B3);
    step();
    check("t1_count", 64'(count), 64'h1);

    // T2
    do_start();
    check("t2_count_clr", 64'(count), 64'h0);
    push(4'd1, 5'd5, 5'd6, 5'd7, 32'h0, 1'b0);
    push(4'd6, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b0);
    push(4'd11, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0);
    repeat (3) step();
    compare_words("t2");
    check("t2_sub", 64'(got_d.size() > 0 ? got_d[0] : 32'h0), 64'h407302B3);
    check("t2_addi", 64'(got_d.size() > 1 ? got_d[1] : 32'h0), 64'hFFF00093);
    check("t2_sw", 64'(got_d.size() > 2 ? got_d[2] : 32'h0), 64'h0020A423);

    // T3
    do_start();
    push(4'd12, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 1'b0);
    push(4'd13, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b1);
    wait_done();
    compare_words("t3");
    check("t3_bne", 64'(got_d.size() > 0 ? got_d[0] : 32'h0), 64'hFE209EE3);
    check("t3_jal", 64'(got_d.size() > 1 ? got_d[1] : 32'h0), 64'h001000EF);
    check("t3_count", 64'(count), 64'h2);

    // T4: backpressure
    do_start();
    mem_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      push(4'($urandom_range(0, 14)), 5'($urandom), 5'($urandom), 5'($urandom), $urandom, 1'b0);
    check("t4_full_in_ready", {63'h0, in_ready}, 64'h0);
    hold_a = mem_addr;
    hold_d = mem_wdata;
    check("t4_head_data", 64'(hold_d), 64'(exp_d[0]));
    repeat (3) step();
    check("t4_hold_we", {63'h0, mem_we}, 64'h1);
    check("t4_hold_addr", 64'(mem_addr), 64'(hold_a));
    check("t4_hold_data", 64'(mem_wdata), 64'(hold_d));
    mem_ready = 1'b1;
    push(4'd14, 5'd9, 5'd0, 5'd0, 32'hABCDE123, 1'b1);
    wait_done();
    compare_words("t4");

    // T5: illegal op
    do_start();
    push(4'd0, 5'd1, 5'd2, 5'd3, 32'h0, 1'b0);
    push(4'd15, 5'd1, 5'd2, 5'd3, 32'h0, 1'b0);
    push(4'd0, 5'd4, 5'd5, 5'd6, 32'h0, 1'b1);
    wait_done();
    compare_words("t5");
    check("t5_err", {63'h0, err}, {63'h0, exp_err});
    check("t5_count", 64'(count), 64'h2);
    do_start();
    check("t5_err_clr", {63'h0, err}, 64'h0);

    // T6: restart and reset mid-load
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(4'd3, 5'd1, 5'd1, 5'd1, 32'h0, 1'b0);
    check("t6_pending_we", {63'h0, mem_we}, 64'h1);
    do_start();
    check("t6_start_we", {63'h0, mem_we}, 64'h0);
    check("t6_start_addr", 64'(mem_addr), 64'h0);
    check("t6_start_busy", {63'h0, busy}, 64'h1);
    for (int i = 0; i < 3; i++) push(4'd4, 5'd2, 5'd2, 5'd2, 32'h0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_rst_we", {63'h0, mem_we}, 64'h0);
    check("t6_rst_busy", {63'h0, busy}, 64'h0);
    check("t6_rst_addr", 64'(mem_addr), 64'h0);
    check("t6_rst_in_ready", {63'h0, in_ready}, 64'h0);

    // Illegal final request: load ends once the FIFO drains
    do_start();
    mem_ready = 1'b1;
    push(4'd9, 5'd7, 5'd8, 5'd0, 32'h123, 1'b0);
    push(4'd15, 5'd0, 5'd0, 5'd0, 32'h0, 1'b1);
    wait_done();
    compare_words("ill_last");
    check("ill_last_err", {63'h0, err}, 64'h1);

    // Randomized program with random memory backpressure
    do_start();
    rnd_ready = 1'b1;
    for (int i = 0; i < 40; i++)
      push(4'($urandom_range(0, 15)), 5'($urandom), 5'($urandom), 5'($urandom),
           $urandom, i == 39);
    wait_done();
    compare_words("rnd");
    check("rnd_err", {63'h0, err}, {63'h0, exp_err});
    check("rnd_count", 64'(count), 64'(exp_a.size()));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
